// File: rtl/serial_branch_comparator.sv
// Digit-serial A - B for branch compares: one DIGIT_WIDTH slice per cycle.
// Produces the full difference and the EQ/NE/LT/GE/LTU/GEU flags.
module serial_branch_comparator #(
    parameter int WIDTH       = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] S,
    output logic             EQ,
    output logic             NE,
    output logic             LT,
    output logic             GE,
    output logic             LTU,
    output logic             GEU
);
    localparam int NDIG = WIDTH / DIGIT_WIDTH;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_q, b_q;
    logic                   carry;
    logic [CW-1:0]          cnt;

    logic [DIGIT_WIDTH-1:0] a_dig, b_dig, d;
    logic                   c_out, v_next, lt_next, last;
    logic [WIDTH-1:0]       s_next;
    int                     lo;

    // One digit of A + ~B + carry; s_next is S with the current digit filled in,
    // so the flags can be registered on the same edge as the final digit.
    always_comb begin
        lo         = int'(cnt) * DIGIT_WIDTH;
        a_dig      = a_q[lo +: DIGIT_WIDTH];
        b_dig      = b_q[lo +: DIGIT_WIDTH];
        {c_out, d} = {1'b0, a_dig} + {1'b0, ~b_dig} + (DIGIT_WIDTH + 1)'(carry);
        s_next     = S;
        s_next[lo +: DIGIT_WIDTH] = d;
        v_next     = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (s_next[WIDTH-1] != a_q[WIDTH-1]);
        lt_next    = s_next[WIDTH-1] ^ v_next;
        last       = (cnt == CW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            S     <= '0;
            EQ    <= 1'b0;
            NE    <= 1'b0;
            LT    <= 1'b0;
            GE    <= 1'b0;
            LTU   <= 1'b0;
            GEU   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= 1'b1;
                        cnt   <= '0;
                        S     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    S     <= s_next;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    // Flags only change here, so they never show a half-built S.
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        EQ    <= (s_next == '0);
                        NE    <= (s_next != '0);
                        LTU   <= ~c_out;
                        GEU   <= c_out;
                        LT    <= lt_next;
                        GE    <= ~lt_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_branch_comparator.sv
// Self-checking bench: directed table, handshake corner sequences and random
// operands against an arithmetic reference model.
module tb_serial_branch_comparator;
    localparam int NDIG = 8;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B, S;
    logic        busy, valid, EQ, NE, LT, GE, LTU, GEU;

    int total = 0;
    int bad   = 0;

    serial_branch_comparator #(.WIDTH(32), .DIGIT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .valid(valid), .S(S),
        .EQ(EQ), .NE(NE), .LT(LT), .GE(GE), .LTU(LTU), .GEU(GEU)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [5:0]  f;   // {EQ,NE,LT,GE,LTU,GEU}
    } vec_t;

    function automatic logic [5:0] flags_now();
        return {EQ, NE, LT, GE, LTU, GEU};
    endfunction

    function automatic logic [5:0] model_flags(input logic [31:0] a, input logic [31:0] b);
        logic eq, lt, ltu;
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        return {eq, ~eq, lt, ~lt, ltu, ~ltu};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands with start high for one edge; returns at the negedge
    // right after the accept edge (cycle 1 of the operation).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at cycle 1. Expects busy for cycles 1..NDIG and valid at NDIG+1.
    // poke_cyc > 0 pulses start with junk operands at that cycle.
    task automatic wait_valid(input string name, input int poke_cyc);
        int cyc, busy_cnt;
        cyc = 1; busy_cnt = 0;
        while (!valid && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == poke_cyc) begin
                start = 1'b1; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, " latency"}, 32'(cyc), 32'(NDIG + 1));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(NDIG));
        chk({name, " busy_at_valid"}, 32'(busy), 32'd0);
    endtask

    task automatic check_res(input string name, input logic [31:0] s, input logic [5:0] f);
        chk({name, " S"}, S, s);
        chk({name, " flags"}, 32'(flags_now()), 32'(f));
    endtask

    // After a valid, valid must drop and outputs hold for n idle cycles.
    task automatic quiet(input string name, input int n, input logic [31:0] s, input logic [5:0] f);
        int pulses;
        logic held;
        pulses = 0; held = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) pulses++;
            if (S !== s || flags_now() !== f) held = 1'b0;
        end
        chk({name, " extra_valid"}, 32'(pulses), 32'd0);
        chk({name, " held"}, 32'(held), 32'd1);
    endtask

    vec_t vt[3];

    initial begin
        vt[0] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 6'b100101};
        vt[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 6'b011010};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 6'b011001};

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        check_res("reset", 32'h0, 6'b000000);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 3; i++) begin
            issue(vt[i].a, vt[i].b);
            chk($sformatf("vec%0d busy_start", i), 32'(busy), 32'd1);
            wait_valid($sformatf("vec%0d", i), 0);
            check_res($sformatf("vec%0d", i), vt[i].s, vt[i].f);
            quiet($sformatf("vec%0d", i), 2, vt[i].s, vt[i].f);
        end

        // Back-to-back: start held in the DONE cycle
        issue(32'h0000_0001, 32'h8000_0000);
        wait_valid("b2b_first", 0);
        check_res("b2b_first", 32'h8000_0001, 6'b010110);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b busy_start", 32'(busy), 32'd1);
        chk("b2b flags_hold_in_run", 32'(flags_now()), 32'(6'b010110));
        wait_valid("b2b_second", 0);
        check_res("b2b_second", 32'h0, 6'b100101);
        quiet("b2b", 2, 32'h0, 6'b100101);

        // Start and operand changes during RUN are ignored
        issue(32'd7, 32'd3);
        A = 32'h1234_5678; B = 32'h9ABC_DEF0;
        wait_valid("run_start", 3);
        check_res("run_start", 32'h4, 6'b010101);
        quiet("run_start", 12, 32'h4, 6'b010101);

        // Reset mid-RUN
        issue(32'h0000_0100, 32'h0000_0001);
        repeat (3) @(negedge clk);   // now at cycle 4
        chk("midreset busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset valid", 32'(valid), 32'd0);
        check_res("midreset", 32'h0, 6'b000000);
        quiet("midreset", 12, 32'h0, 6'b000000);
        issue(32'h0000_0100, 32'h0000_0001);
        wait_valid("after_reset", 0);
        check_res("after_reset", 32'h0000_00FF, model_flags(32'h100, 32'h1));

        // Random operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ 32'h8000_0000;
                default: rb = $urandom;
            endcase
            issue(ra, rb);
            wait_valid($sformatf("rnd%0d", i), 0);
            check_res($sformatf("rnd%0d a=%h b=%h", i, ra, rb), ra - rb, model_flags(ra, rb));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
